// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_D, OWN_X} owner_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
  localparam int unsigned CNT_W         = 8;

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Memory wait-state counter: held clear outside an access, counts up inside it,
// flags terminal count when it reaches TIMEOUT.
module wait_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic arst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter/sequencer: loader, data and fetch requesters share
// one memory through an IDLE -> ACCESS -> RESP handshake with wait-state timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_gnt,
  output logic          x_rvalid,
  output logic [DW-1:0] rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ready,
  input  logic [DW-1:0] m_rdata,
  output logic          core_en,
  output logic          err
);

  state_t        state, state_nx;
  owner_t        owner, sel;
  logic          gnt_any;
  logic          core_req;
  logic          last_x;
  logic          tmo_tc;
  logic          in_access, in_resp;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  assign core_req  = if_req | d_req;
  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP);

  // Loader normally wins, but after a loader grant a waiting core gets the next slot.
  always_comb begin
    state_nx = state;
    sel      = OWN_IF;
    gnt_any  = 1'b0;
    case (state)
      IDLE: begin
        if (x_req && !(last_x && core_req)) begin
          sel     = OWN_X;
          gnt_any = 1'b1;
        end else if (d_req) begin
          sel     = OWN_D;
          gnt_any = 1'b1;
        end else if (if_req) begin
          sel     = OWN_IF;
          gnt_any = 1'b1;
        end
        if (gnt_any) state_nx = ACCESS;
      end
      ACCESS: begin
        if (m_ready || tmo_tc) state_nx = RESP;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      owner     <= OWN_IF;
      last_x    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (gnt_any) begin
        owner  <= sel;
        last_x <= (sel == OWN_X);
        case (sel)
          OWN_X: begin
            lat_we    <= x_we;
            lat_addr  <= x_addr;
            lat_wdata <= x_wdata;
          end
          OWN_D: begin
            lat_we    <= d_we;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
          end
          default: begin
            lat_we    <= 1'b0;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
          end
        endcase
      end
      if (in_access && (m_ready || tmo_tc)) begin
        if (m_ready) begin
          rdata_q <= lat_we ? '0 : m_rdata;
        end else begin
          rdata_q <= DW'(TIMEOUT_RDATA);
          err_q   <= 1'b1;
        end
      end
    end
  end

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk  (clk),
    .arst (arst),
    .clr  (!in_access),
    .inc  (in_access),
    .tc   (tmo_tc)
  );

  assign if_gnt    = gnt_any && (sel == OWN_IF);
  assign d_gnt     = gnt_any && (sel == OWN_D);
  assign x_gnt     = gnt_any && (sel == OWN_X);
  assign if_rvalid = in_resp && (owner == OWN_IF);
  assign d_rvalid  = in_resp && (owner == OWN_D);
  assign x_rvalid  = in_resp && (owner == OWN_X);

  assign m_req   = in_access;
  assign m_we    = in_access && lat_we;
  assign m_addr  = lat_addr;
  assign m_wdata = lat_wdata;
  assign rdata   = rdata_q;
  assign err     = err_q;

  assign core_en = !core_req || (in_resp && (owner != OWN_X));

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and sequencer for the RV32I multicycle core. It shares one unified instruction/data memory between the core's instruction-fetch requester, the core's load/store requester and an external program loader. It sequences each access through a request/wait/response handshake with variable-latency memory and a wait-state timeout. It also produces the core's stall enable.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, maximum wait cycles for m_ready before an access is aborted (1..255)

Ports:
- clk  in  1  system clock, all state on rising edge
- arst  in  1  asynchronous, active-low reset
- if_req  in  1  instruction fetch request (read only)
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch granted
- if_rvalid  out  1  fetch response valid
- d_req  in  1  core data request
- d_we  in  1  core data write
- d_addr  in  AW  core data address
- d_wdata  in  DW  core store data
- d_gnt  out  1  core data granted
- d_rvalid  out  1  core data response valid
- x_req  in  1  external loader request
- x_we  in  1  loader write
- x_addr  in  AW  loader address
- x_wdata  in  DW  loader write data
- x_gnt  out  1  loader granted
- x_rvalid  out  1  loader response valid
- rdata  out  DW  response data, shared by all requesters, qualified by *_rvalid
- m_req  out  1  memory access strobe
- m_we  out  1  memory write
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_ready  in  1  memory access complete (read data valid if read)
- m_rdata  in  DW  memory read data
- core_en  out  1  core clock-enable (0 = stall)
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: select one requester. Pulse its *_gnt for one cycle, combinationally in the same cycle as its req. Latch owner, we, addr and wdata. Go to ACCESS.
- Priority: x > d > if. Exception: after an x grant, the fairness flag last_x is set. If last_x=1 and d_req or if_req is high, the core wins. last_x clears on any core grant.
- ACCESS: m_req=1, with m_we/m_addr/m_wdata from the latch. The wait counter increments each cycle.
  - If m_ready=1: capture m_rdata into rdata (writes capture 0) and go to RESP.
  - If the counter reaches TIMEOUT without m_ready: set rdata=32'hDEAD_BEEF, set err, and go to RESP.
- RESP: pulse the owner's *_rvalid for exactly one cycle. m_req=0. Return to IDLE.
- Requesters hold req and payload until gnt. req may drop after gnt. Payload changes after gnt are ignored.
- core_en = 0 while if_req or d_req is high, except in the cycle the core owner's rvalid is high. Otherwise core_en = 1. This is combinational.
- err clears only on reset.

## Timing
- Reset values: FSM IDLE, all *_gnt/*_rvalid 0, m_req 0, m_we 0, m_addr 0, m_wdata 0, rdata 0, err 0, counter 0, last_x 0, core_en 1 when no core req.
- Zero-wait memory (m_ready in first ACCESS cycle):
  - req/gnt at cycle 0
  - m_req at cycle 1
  - rvalid at cycle 2
  - next grant earliest at cycle 3
- Each memory wait cycle adds one cycle.
- Simultaneous requests are resolved only in IDLE. Requests arriving in ACCESS or RESP wait.
- m_ready seen in the cycle the counter hits TIMEOUT: treated as success, no err.
- m_ready while not in ACCESS: ignored.
- Reset mid-access: all outputs return to reset values immediately (asynchronous). The in-flight access is dropped with no rvalid.
- Counter width is 8 bits. It clears on entering ACCESS.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - owner enum {OWN_IF, OWN_D, OWN_X}
  - TIMEOUT_RDATA = 32'hDEAD_BEEF
- One sub-module, wait_timer: the clear/increment counter with a terminal-count flag at TIMEOUT.

## Test plan
- Single fetch, m_ready in the first ACCESS cycle, m_rdata=32'h00500093 -> if_gnt at cycle 0, if_rvalid with rdata=32'h00500093 at cycle 2, core_en low at cycles 0–1 and high at cycle 2.
- d_req and if_req asserted together -> d granted first, if granted at the cycle after d_rvalid, m_addr follows d_addr then if_addr.
- x_req held continuously while d_req is high -> grants alternate x, d, x; x never gets two consecutive grants while the core is waiting.
- d store to 32'h100 with data 32'hCAFEF00D and 3 wait states -> m_we=1 and m_req high for 4 cycles, d_rvalid one cycle later with rdata=0.
- m_ready never asserted, TIMEOUT=15 -> rvalid 16 cycles after m_req rises, rdata=32'hDEAD_BEEF, err=1 and stays 1.
- arst driven low during the ACCESS state -> m_req and err drop at once, no rvalid; after release a fresh if_req completes normally.
